// File: rtl/pix_collect.sv
// Result collector: accepts (x, y, iter) results from workers, buffers them
// in a small FIFO and commits each one to the framebuffer as a linear address.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset, no frame limits loaded, nothing accepted
// COLLECT | frame in progress, accepting results and draining writes
// DONE    | every pixel committed; leftover FIFO entries still drain
module pix_collect #(
    parameter int NUM_X_BITS = 10,
    parameter int NUM_Y_BITS = 10,
    parameter int ITER_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [NUM_X_BITS-1:0]            x_max_i,
    input  logic [NUM_Y_BITS-1:0]            y_max_i,
    input  logic                             res_valid_i,
    output logic                             res_ready_o,
    input  logic [NUM_X_BITS-1:0]            res_x_i,
    input  logic [NUM_Y_BITS-1:0]            res_y_i,
    input  logic [ITER_BITS-1:0]             res_iter_i,
    output logic                             mem_wr_en_o,
    output logic [NUM_X_BITS+NUM_Y_BITS-1:0] mem_addr_o,
    output logic [ITER_BITS-1:0]             mem_data_o,
    input  logic                             mem_ack_i,
    output logic [NUM_X_BITS+NUM_Y_BITS:0]   pix_count_o,
    output logic                             frame_done_o,
    output logic                             err_oob_o
);

    localparam int AW = NUM_X_BITS + NUM_Y_BITS;
    localparam int CW = AW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_X_BITS-1:0]   x_max_q, x_max_d;
    logic [NUM_Y_BITS-1:0]   y_max_q, y_max_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW:0]             fill_q, fill_d;
    logic [CW-1:0]           pix_count_q, pix_count_d;
    logic                    err_oob_q, err_oob_d;

    logic [AW-1:0]           fifo_addr_q [FIFO_DEPTH];
    logic [ITER_BITS-1:0]    fifo_data_q [FIFO_DEPTH];

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    accept;
    logic                    oob;
    logic                    push;
    logic                    pop;
    logic [AW-1:0]           row_len;
    logic [AW-1:0]           res_addr;
    logic [CW-1:0]           total;

    // Handshake, address translation and frame size, all from registered state.
    always_comb begin
        fifo_full   = (fill_q == (PW+1)'(FIFO_DEPTH));
        fifo_empty  = (fill_q == '0);
        res_ready_o = (state_q == COLLECT) && !fifo_full && !start_i;
        accept      = res_valid_i && res_ready_o;
        oob         = (res_x_i > x_max_q) || (res_y_i > y_max_q);
        push        = accept && !oob;
        pop         = !fifo_empty && mem_ack_i;
        // Full-width product: a 1024x1024 frame needs the extra count bit.
        total       = (CW'(x_max_q) + CW'(1)) * (CW'(y_max_q) + CW'(1));
        row_len     = AW'(x_max_q) + AW'(1);
        res_addr    = AW'(res_y_i) * row_len + AW'(res_x_i);
    end

    // Next-state: restart on start, else FIFO bookkeeping and frame completion.
    always_comb begin
        state_d     = state_q;
        x_max_d     = x_max_q;
        y_max_d     = y_max_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        pix_count_d = pix_count_q;
        err_oob_d   = err_oob_q;

        if (start_i) begin
            // A restart discards anything still buffered, including a
            // write that memory may be acknowledging this very cycle.
            state_d     = COLLECT;
            x_max_d     = x_max_i;
            y_max_d     = y_max_i;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            pix_count_d = '0;
            err_oob_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (pix_count_q != total) begin
                    pix_count_d = pix_count_q + CW'(1);
                end
            end
            case ({push, pop})
                2'b10:   fill_d = fill_q + (PW+1)'(1);
                2'b01:   fill_d = fill_q - (PW+1)'(1);
                default: fill_d = fill_q;
            endcase
            if (accept && oob) begin
                err_oob_d = 1'b1;
            end
            if ((state_q == COLLECT) && (pix_count_d == total)) begin
                state_d = DONE;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_max_q     <= '0;
            y_max_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            pix_count_q <= '0;
            err_oob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_max_q     <= x_max_d;
            y_max_q     <= y_max_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            pix_count_q <= pix_count_d;
            err_oob_q   <= err_oob_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= res_addr;
            fifo_data_q[wr_ptr_q] <= res_iter_i;
        end
    end

    // Write port shows the FIFO head; forced to zero when nothing is pending.
    always_comb begin
        mem_wr_en_o  = !fifo_empty;
        mem_addr_o   = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
        mem_data_o   = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
        pix_count_o  = pix_count_q;
        frame_done_o = (state_q == DONE);
        err_oob_o    = err_oob_q;
    end

endmodule

// File: tb/tb_pix_collect.sv
// Directed bench for pix_collect: a raster-frame vector table plus
// hand-written multi-cycle sequences for backpressure, out-of-range drops,
// push/pop overlap, restart and asynchronous reset.
module tb_pix_collect;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  x_max;
    logic [9:0]  y_max;
    logic        res_valid;
    logic        res_ready;
    logic [9:0]  res_x;
    logic [9:0]  res_y;
    logic [7:0]  res_iter;
    logic        mem_wr_en;
    logic [19:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic [20:0] pix_count;
    logic        frame_done;
    logic        err_oob;

    int checks = 0;
    int errors = 0;

    pix_collect #(
        .NUM_X_BITS(10),
        .NUM_Y_BITS(10),
        .ITER_BITS (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .x_max_i     (x_max),
        .y_max_i     (y_max),
        .res_valid_i (res_valid),
        .res_ready_o (res_ready),
        .res_x_i     (res_x),
        .res_y_i     (res_y),
        .res_iter_i  (res_iter),
        .mem_wr_en_o (mem_wr_en),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .mem_ack_i   (mem_ack),
        .pix_count_o (pix_count),
        .frame_done_o(frame_done),
        .err_oob_o   (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  it;
        logic        ack;
        logic        e_rdy;
        logic        e_wr;
        logic [19:0] e_addr;
        logic [7:0]  e_data;
        logic [20:0] e_cnt;
        logic        e_done;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1ns after the next rising edge, where inputs are driven.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; res_ready must be low during it.
    task automatic start_frame(input logic [9:0] xm, input logic [9:0] ym);
        start     = 1'b1;
        x_max     = xm;
        y_max     = ym;
        res_valid = 1'b0;
        #4;
        chk("start_ready_low", res_ready, 0);
        next_cyc();
        start = 1'b0;
    endtask

    task automatic drive_res(input logic v, input int x, input int y, input int it);
        res_valid = v;
        res_x     = 10'(x);
        res_y     = 10'(y);
        res_iter  = 8'(it);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Raster frame 4x2, mem_ack high: one write per cycle after 1-cycle latency.
        for (int k = 0; k < 10; k++) begin
            tbl[k].v      = (k < 8);
            tbl[k].x      = 10'(k % 4);
            tbl[k].y      = 10'(k / 4);
            tbl[k].it     = 8'((k % 4) + 4 * (k / 4));
            tbl[k].ack    = 1'b1;
            tbl[k].e_rdy  = (k < 9);
            tbl[k].e_wr   = (k >= 1) && (k <= 8);
            tbl[k].e_addr = (k >= 1 && k <= 8) ? 20'(k - 1) : 20'd0;
            tbl[k].e_data = (k >= 1 && k <= 8) ? 8'(k - 1) : 8'd0;
            tbl[k].e_cnt  = (k == 0) ? 21'd0 : (k <= 8 ? 21'(k - 1) : 21'd8);
            tbl[k].e_done = (k == 9);
        end

        rst       = 1'b1;
        start     = 1'b0;
        x_max     = '0;
        y_max     = '0;
        res_valid = 1'b0;
        res_x     = '0;
        res_y     = '0;
        res_iter  = '0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", res_ready, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_count", pix_count, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", err_oob, 0);
        rst = 1'b0;
        next_cyc();
        #4;
        chk("idle_ready", res_ready, 0);
        next_cyc();

        // ---- raster frame from table ----
        start_frame(10'd3, 10'd1);
        for (int k = 0; k < 10; k++) begin
            drive_res(tbl[k].v, int'(tbl[k].x), int'(tbl[k].y), int'(tbl[k].it));
            mem_ack = tbl[k].ack;
            #4;
            chk("tbl_ready", res_ready, tbl[k].e_rdy);
            chk("tbl_wr_en", mem_wr_en, tbl[k].e_wr);
            if (tbl[k].e_wr) begin
                chk("tbl_addr", mem_addr, tbl[k].e_addr);
                chk("tbl_data", mem_data, tbl[k].e_data);
            end
            chk("tbl_count", pix_count, tbl[k].e_cnt);
            chk("tbl_done", frame_done, tbl[k].e_done);
            next_cyc();
        end
        drive_res(0, 0, 0, 0);

        // ---- backpressure: mem_ack low, res_valid held high ----
        start_frame(10'd3, 10'd1);
        #4;
        chk("restart_done_clr", frame_done, 0);
        next_cyc();
        mem_ack = 1'b0;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            drive_res(1, acc % 4, acc / 4, 8'h10 + acc);
            #4;
            if (acc > 0) begin
                chk("bp_wr_en", mem_wr_en, 1);
                chk("bp_addr_stable", mem_addr, 0);
                chk("bp_data_stable", mem_data, 8'h10);
            end
            if (res_ready) acc++;
            next_cyc();
        end
        chk("bp_accepts", acc, 4);
        drive_res(0, 0, 0, 0);
        mem_ack = 1'b1;
        for (int d = 0; d < 5; d++) begin
            #4;
            if (d < 4) begin
                chk("drain_wr_en", mem_wr_en, 1);
                chk("drain_addr", mem_addr, d);
                chk("drain_data", mem_data, 8'h10 + d);
            end else begin
                chk("drain_empty", mem_wr_en, 0);
            end
            if (d == 0) chk("full_pop_ready", res_ready, 0);
            if (d == 1) chk("after_pop_ready", res_ready, 1);
            next_cyc();
        end
        chk("drain_count", pix_count, 4);

        // ---- out-of-range results dropped ----
        drive_res(1, 4, 0, 8'hEE);
        #4;
        chk("oob1_ready", res_ready, 1);
        next_cyc();
        drive_res(1, 0, 2, 8'hEF);
        #4;
        chk("oob2_ready", res_ready, 1);
        chk("oob1_no_write", mem_wr_en, 0);
        chk("oob1_err", err_oob, 1);
        next_cyc();
        drive_res(0, 0, 0, 0);
        #4;
        chk("oob2_no_write", mem_wr_en, 0);
        chk("oob_count", pix_count, 4);
        next_cyc();
        #4;
        chk("oob_sticky", err_oob, 1);
        chk("oob_not_done", frame_done, 0);
        next_cyc();

        // ---- simultaneous push/pop with two entries buffered ----
        mem_ack = 1'b0;
        drive_res(1, 0, 1, 8'h24);
        next_cyc();
        drive_res(1, 1, 1, 8'h25);
        next_cyc();
        mem_ack = 1'b1;
        drive_res(1, 2, 1, 8'h26);
        #4;
        chk("pp_ready0", res_ready, 1);
        chk("pp_addr0", mem_addr, 4);
        chk("pp_data0", mem_data, 8'h24);
        next_cyc();
        drive_res(1, 3, 1, 8'h27);
        #4;
        chk("pp_ready1", res_ready, 1);
        chk("pp_addr1", mem_addr, 5);
        chk("pp_data1", mem_data, 8'h25);
        next_cyc();
        drive_res(0, 0, 0, 0);
        #4;
        chk("pp_addr2", mem_addr, 6);
        chk("pp_data2", mem_data, 8'h26);
        next_cyc();
        #4;
        chk("pp_addr3", mem_addr, 7);
        chk("pp_data3", mem_data, 8'h27);
        chk("pp_wr3", mem_wr_en, 1);
        next_cyc();
        #4;
        chk("pp_empty", mem_wr_en, 0);
        chk("pp_count", pix_count, 8);
        chk("pp_done", frame_done, 1);
        chk("pp_err_held", err_oob, 1);
        next_cyc();

        // ---- restart mid-frame with three entries buffered ----
        start_frame(10'd3, 10'd1);
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_res(1, k, 0, 8'h50 + k);
            next_cyc();
        end
        drive_res(0, 0, 0, 0);
        #4;
        chk("pre_restart_wr", mem_wr_en, 1);
        next_cyc();
        start_frame(10'd1, 10'd1);
        #4;
        chk("restart_wr_en", mem_wr_en, 0);
        chk("restart_count", pix_count, 0);
        chk("restart_done", frame_done, 0);
        chk("restart_err", err_oob, 0);
        mem_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive_res(1, k % 2, k / 2, 8'h30 + k);
            else       drive_res(0, 0, 0, 0);
            #4;
            if (k >= 1 && k <= 4) begin
                chk("nf_wr_en", mem_wr_en, 1);
                chk("nf_addr", mem_addr, k - 1);
                chk("nf_data", mem_data, 8'h30 + k - 1);
            end
            if (k == 5) begin
                chk("nf_count", pix_count, 4);
                chk("nf_done", frame_done, 1);
            end
            next_cyc();
        end

        // ---- asynchronous reset while a write is pending ----
        start_frame(10'd3, 10'd1);
        mem_ack = 1'b0;
        drive_res(1, 1, 0, 8'h41);
        next_cyc();
        drive_res(1, 2, 0, 8'h42);
        #1;
        chk("pre_rst_wr", mem_wr_en, 1);
        chk("pre_rst_addr", mem_addr, 1);
        rst = 1'b1;
        #1;
        chk("arst_ready", res_ready, 0);
        chk("arst_wr_en", mem_wr_en, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_data", mem_data, 0);
        chk("arst_count", pix_count, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_err", err_oob, 0);
        #1;
        rst = 1'b0;
        next_cyc();
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("post_rst_ready", res_ready, 0);
            chk("post_rst_wr", mem_wr_en, 0);
            next_cyc();
        end
        drive_res(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pix_collect.md
Name: pix_collect

Overview:
- Consumer end of the work-dispatch path.
- Pixel results come back from workers tagged with the (x, y) coordinates issued by the dispatcher's pixel incrementer. This block accepts them over a valid/ready handshake and buffers them in a small FIFO.
- Each result is translated to a linear framebuffer address (y*(x_max+1)+x) and written to memory through a write/ack interface.
- frame_done is raised once every pixel of the frame has been committed.

Parameters:
- NUM_X_BITS, 10, width of x coordinate and x_max
- NUM_Y_BITS, 10, width of y coordinate and y_max
- ITER_BITS, 8, width of iteration-count result
- FIFO_DEPTH, 4, result buffer entries (power of 2, >=2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; latches x_max/y_max, clears counts and FIFO, begins a frame
- x_max  in  NUM_X_BITS  last x index of frame (width = x_max+1)
- y_max  in  NUM_Y_BITS  last y index of frame
- res_valid  in  1  worker result valid
- res_ready  out  1  block can accept a result this cycle
- res_x  in  NUM_X_BITS  result x coordinate
- res_y  in  NUM_Y_BITS  result y coordinate
- res_iter  in  ITER_BITS  iteration count for the pixel
- mem_wr_en  out  1  write request
- mem_addr  out  NUM_X_BITS+NUM_Y_BITS  framebuffer word address
- mem_data  out  ITER_BITS  write data
- mem_ack  in  1  memory accepted write this cycle
- pix_count  out  NUM_X_BITS+NUM_Y_BITS+1  pixels committed this frame
- frame_done  out  1  level; all pixels committed
- err_oob  out  1  sticky; an out-of-range result was dropped

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, FIFO empty.
  - res_ready=0, mem_wr_en=0, mem_addr=0, mem_data=0, pix_count=0, frame_done=0, err_oob=0.
  - Latched x_max/y_max=0.
- FSM states IDLE, COLLECT, DONE:
  - IDLE -> COLLECT on start.
  - COLLECT -> DONE in the cycle after the commit that makes pix_count equal total.
  - DONE -> COLLECT on start.
  - start in any state restarts: latches new limits, flushes FIFO, clears pix_count/frame_done/err_oob. mem_wr_en is 0 in the following cycle.
- total = (x_max_l+1)*(y_max_l+1), computed at full width NUM_X_BITS+NUM_Y_BITS+1 with no truncation. Max frame 1024x1024 gives total 2^20.
- Handshake:
  - res_ready = (state==COLLECT) & !fifo_full & !start. Combinational from registered state only; independent of res_valid.
  - Accept = res_valid & res_ready.
  - Inputs are ignored when res_ready=0.
- On accept:
  - If res_x>x_max_l or res_y>y_max_l: result dropped, err_oob set (sticky), nothing enqueued.
  - Otherwise push {addr, res_iter}, where addr = res_y*(x_max_l+1)+res_x, truncated to NUM_X_BITS+NUM_Y_BITS. In-range values never overflow.
- Write side:
  - mem_wr_en=1 whenever the FIFO is non-empty.
  - mem_addr/mem_data show the FIFO head and are held stable until mem_ack.
  - On mem_wr_en & mem_ack: pop, and pix_count increments.
  - mem_ack while mem_wr_en=0 is ignored.
- Latency: a result accepted in cycle N is presented on mem_* at earliest N+1 (registered FIFO, no bypass).
- Throughput: 1 result/cycle with mem_ack held high.
- Simultaneous push and pop in the same cycle: both take effect, occupancy unchanged.
- Full FIFO: res_ready=0. A pop in that cycle does not raise res_ready until the next cycle.
- Duplicate coordinates are not detected; each committed write counts.
- Writes that remain in the FIFO when the count reaches total are still drained; pix_count saturates at total.
- frame_done = (state==DONE). It holds until start or rst.
- rst mid-frame discards all buffered results; a partially presented write is abandoned.

Test Plan:
- Reset then start with x_max=3, y_max=1, mem_ack tied 1; feed 8 results in raster order with res_iter=x+4y:
  - mem_addr sequence 0..7 with matching data.
  - pix_count=8.
  - frame_done=1 one cycle after the 8th ack.
- mem_ack held 0, res_valid held 1:
  - Exactly FIFO_DEPTH=4 accepts, then res_ready=0.
  - mem_addr/mem_data stay stable.
  - Releasing mem_ack drains 4 writes in 4 cycles, then res_ready returns to 1.
- x_max=3, y_max=1; send res_x=4,y=0 then res_x=0,y=2:
  - Both accepted, no write.
  - err_oob=1 and stays 1.
  - pix_count unchanged.
- Simultaneous push/pop with FIFO at 2 entries:
  - Occupancy stays 2.
  - Results emerge in order with one-cycle latency.
- start asserted mid-frame with 3 entries buffered:
  - Next cycle mem_wr_en=0, pix_count=0, new limits used.
  - A new full frame completes correctly.
- rst pulsed while mem_wr_en=1:
  - All outputs go to 0 immediately (asynchronously), state=IDLE.
  - res_ready=0 until start.
